full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The module SHALL have no parameters; all data ports are 1 bit wide.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-004 The module SHALL have port a, input, 1 bit, addend bit.
REQ-005 The module SHALL have port b, input, 1 bit, addend bit.
REQ-006 The module SHALL have port c, input, 1 bit, carry-in bit.
REQ-007 The module SHALL have port en, input, 1 bit, register-update enable.
REQ-008 The module SHALL have port serial, input, 1 bit, bit-serial mode select.
REQ-009 The module SHALL have port sum, output, 1 bit, combinational sum bit.
REQ-010 The module SHALL have port carry, output, 1 bit, combinational carry-out bit.
REQ-011 The module SHALL have port sum_q, output, 1 bit, registered sum.
REQ-012 The module SHALL have port carry_q, output, 1 bit, registered carry.
REQ-013 The module SHALL have port valid_q, output, 1 bit, set while sum_q/carry_q hold a computed result.

Function
REQ-014 The module SHALL drive sum = a XOR b XOR c, purely combinational, independent of clk, rst, en and serial.
REQ-015 The module SHALL drive carry = (a AND b) OR (a AND c) OR (b AND c), purely combinational.
REQ-016 The full truth table SHALL hold: {a,b,c} = 000->sum 0,carry 0; 001/010/100->1,0; 011/101/110->0,1; 111->1,1.
REQ-017 The module SHALL define the effective carry-in ci as c when serial=0, and as carry_q when serial=1.
REQ-018 On a rising clk edge with rst=0 and en=1, the module SHALL load sum_q <= a^b^ci and carry_q <= maj(a,b,ci), and set valid_q <= 1.
REQ-019 Registered results SHALL have a latency of exactly one cycle from the sampled inputs.
REQ-020 On a rising clk edge with rst=0 and en=0, the module SHALL hold sum_q, carry_q and valid_q unchanged.
REQ-021 In serial mode the module SHALL act as a bit-serial adder: one operand bit pair per enabled cycle, LSB first, with carry propagating through carry_q.
REQ-022 When serial is toggled between cycles, the module SHALL use the mode value sampled at the same edge as the data.
REQ-023 The combinational outputs sum and carry SHALL always use input c, never carry_q, regardless of serial.
REQ-024 The design SHALL contain no latches and no combinational loops; the carry_q feedback path is registered.

Reset
REQ-025 When rst=1 at a rising clk edge, the module SHALL clear sum_q, carry_q and valid_q to 0, with priority over en.
REQ-026 Reset SHALL NOT affect the combinational outputs sum and carry.
REQ-027 A reset asserted in the middle of a serial addition SHALL discard the pending carry, so the next enabled cycle starts with ci=0 in serial mode.
REQ-028 Before the first clk edge with rst=1, the registered outputs SHALL be considered undefined; the bench SHALL apply reset first.

Verification
REQ-029 Exhaustive combinational check: toggle a every 1 time unit, b every 2 and c every 4, sweeping 000..111 -> sum/carry match REQ-016 at every step, with no clock needed.
REQ-030 Registered check: serial=0, en=1, {a,b,c}=111 -> after one edge sum_q=1, carry_q=1, valid_q=1.
REQ-031 Hold check: load 011 (sum_q=0, carry_q=1), then en=0 with inputs 000 for 3 edges -> sum_q=0, carry_q=1 unchanged.
REQ-032 Serial add: after reset, serial=1, en=1, feed A=0b1011 and B=0b0110 LSB first over 4 cycles -> sum_q sequence 1,0,0,0 and final carry_q=1 (total 17).
REQ-033 Reset priority: rst=1 with en=1 and inputs 111 -> sum_q=0, carry_q=0, valid_q=0, while sum=1 and carry=1 combinationally.
REQ-034 Mid-operation reset: in serial mode with carry_q=1, assert rst for one edge, then feed a=1, b=0 -> sum_q=1, carry_q=0.

Source files
------------

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : 1-bit full adder with combinational sum/carry outputs and a
//               registered result stage. In serial mode the registered carry
//               is fed back as carry-in, forming an LSB-first bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic en,
    input  logic serial,
    output logic sum,
    output logic carry,
    output logic sum_q,
    output logic carry_q,
    output logic valid_q
);

    logic r_sum_q;
    logic r_carry_q;
    logic r_valid_q;

    logic w_ci;
    logic w_sum_next;
    logic w_carry_next;

    // Combinational adder: always uses the c port, never the registered carry.
    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (a & c) | (b & c);
    end

    // Effective carry-in for the registered stage; the feedback path comes
    // from a flop, so serial mode introduces no combinational loop.
    always_comb begin
        w_ci         = serial ? r_carry_q : c;
        w_sum_next   = a ^ b ^ w_ci;
        w_carry_next = (a & b) | (a & w_ci) | (b & w_ci);
    end

    // Result registers: reset dominates enable; disabled cycles hold state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_q   <= 1'b0;
            r_carry_q <= 1'b0;
            r_valid_q <= 1'b0;
        end else if (en) begin
            r_sum_q   <= w_sum_next;
            r_carry_q <= w_carry_next;
            r_valid_q <= 1'b1;
        end
    end

    assign sum_q   = r_sum_q;
    assign carry_q = r_carry_q;
    assign valid_q = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder
// Description : Self-checking bench for full_adder: table-driven truth-table
//               sweep plus directed sequences for the registered stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic c;
    logic en;
    logic serial;
    logic sum;
    logic carry;
    logic sum_q;
    logic carry_q;
    logic valid_q;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic exp_sum;
        logic exp_carry;
    } comb_vec_t;

    comb_vec_t comb_tbl [8];

    full_adder dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .en      (en),
        .serial  (serial),
        .sum     (sum),
        .carry   (carry),
        .sum_q   (sum_q),
        .carry_q (carry_q),
        .valid_q (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ia, input logic ib, input logic ic,
                         input logic ien, input logic iser, input logic irst);
        a      = ia;
        b      = ib;
        c      = ic;
        en     = ien;
        serial = iser;
        rst    = irst;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Truth table, indexed as {c,b,a} so a toggles fastest, then b, then c.
        comb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        comb_tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        comb_tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        comb_tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        comb_tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        comb_tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        comb_tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        comb_tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Exhaustive combinational sweep, one step per time unit.
        for (int i = 0; i < 8; i++) begin
            a = comb_tbl[i].a;
            b = comb_tbl[i].b;
            c = comb_tbl[i].c;
            #1;
            chk($sformatf("comb_sum[%0d]", i),   sum,   comb_tbl[i].exp_sum);
            chk($sformatf("comb_carry[%0d]", i), carry, comb_tbl[i].exp_carry);
        end

        // Reset state; reset must leave the combinational path alone.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("rst_sum_q",   sum_q,   1'b0);
        chk("rst_carry_q", carry_q, 1'b0);
        chk("rst_valid_q", valid_q, 1'b0);
        chk("rst_sum",     sum,     1'b1);
        chk("rst_carry",   carry,   1'b1);

        // Parallel load of 111.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("load111_sum_q",   sum_q,   1'b1);
        chk("load111_carry_q", carry_q, 1'b1);
        chk("load111_valid_q", valid_q, 1'b1);

        // Load 011 then hold for three disabled edges with inputs 000.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("load011_sum_q",   sum_q,   1'b0);
        chk("load011_carry_q", carry_q, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_sum_q[%0d]", i),   sum_q,   1'b0);
            chk($sformatf("hold_carry_q[%0d]", i), carry_q, 1'b1);
            chk($sformatf("hold_valid_q[%0d]", i), valid_q, 1'b1);
        end

        // Serial add 1011 + 0110 = 10001, LSB first; c=1 must be ignored.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        begin
            logic [3:0] opa;
            logic [3:0] opb;
            logic [3:0] exp_s;
            opa   = 4'b1011;
            opb   = 4'b0110;
            exp_s = 4'b0001;
            for (int i = 0; i < 4; i++) begin
                drive(opa[i], opb[i], 1'b1, 1'b1, 1'b1, 1'b0);
                tick();
                chk($sformatf("serial_sum_q[%0d]", i), sum_q, exp_s[i]);
            end
            chk("serial_carry_q", carry_q, 1'b1);
        end

        // With carry_q=1 in serial mode, the combinational path still uses c.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("serial_comb_sum",   sum,   1'b1);
        chk("serial_comb_carry", carry, 1'b0);

        // Mode sampled with data: serial=0 uses c=0 even though carry_q=1.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("par_after_ser_sum_q",   sum_q,   1'b1);
        chk("par_after_ser_carry_q", carry_q, 1'b0);

        // Rebuild carry_q=1 in serial mode, then reset mid-operation.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("pre_rst_carry_q", carry_q, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("midrst_sum_q",   sum_q,   1'b0);
        chk("midrst_carry_q", carry_q, 1'b0);
        chk("midrst_valid_q", valid_q, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("post_rst_sum_q",   sum_q,   1'b1);
        chk("post_rst_carry_q", carry_q, 1'b0);
        chk("post_rst_valid_q", valid_q, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
